store_seq_checker: RTL and testbench

- Synthesisable, parametrised checker that watches a processor's data-memory store bus (memwrite/dataadr/writedata) and compares stores, in order, against a loaded table of up to DEPTH expected (address, data) pairs.
- Reports sticky pass/fail with failure capture, an ignore-address filter and a cycle timeout.
- Sits beside the single-cycle/multicycle CPU top in self-checking benches and FPGA bring-up; replaces per-test hand-written memwrite checks.

---
 rtl/store_seq_checker.sv | 157 +++++++++++++++
 tb/tb_store_seq_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/store_seq_checker.sv
// store_seq_checker: watches a CPU data-memory store bus and compares each
// store, in order, against a loaded table of expected (address, data) pairs.
// Reports sticky pass/fail, captures the first mismatching store, can skip a
// designated "ignore" address, and fails on a cycle timeout.
module store_seq_checker #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int IDXW       = 3,
    parameter int IGNORE_ADR = 80,
    parameter int TIMEOUT    = 1000,
    parameter int TCW        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic [WIDTH-1:0] cfg_adr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [IDXW:0]    cfg_num,
    input  logic             ign_en,
    input  logic             start,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [IDXW:0]    match_cnt,
    output logic [WIDTH-1:0] fail_adr,
    output logic [WIDTH-1:0] fail_data
);

    localparam logic [IDXW:0]    DEPTH_W = (IDXW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] IGN_W   = WIDTH'(IGNORE_ADR);
    localparam logic [TCW-1:0]   TOUT_W  = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_tab_adr  [DEPTH];
    logic [WIDTH-1:0] r_tab_data [DEPTH];
    logic [IDXW-1:0]  r_ptr;
    logic [IDXW:0]    r_num;
    logic             r_ign;
    logic [TCW-1:0]   r_tcnt;

    logic [IDXW:0]    w_num_clamp;
    logic             w_ignored;
    logic             w_store;
    logic             w_hit;
    logic             w_last;
    logic             w_tout;

    assign w_num_clamp = (cfg_num > DEPTH_W) ? DEPTH_W : cfg_num;
    assign w_ignored   = r_ign && (dataadr == IGN_W);
    assign w_store     = memwrite && !w_ignored;
    assign w_hit       = (dataadr == r_tab_adr[r_ptr]) && (writedata == r_tab_data[r_ptr]);
    assign w_last      = ({1'b0, r_ptr} == (r_num - 1'b1));
    assign w_tout      = (r_tcnt == TOUT_W);

    // Expected-store table: loadable only while idle; contents survive reset
    // so a run can be restarted without reloading.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && cfg_we && ({1'b0, cfg_idx} < DEPTH_W)) begin
            r_tab_adr[cfg_idx]  <= cfg_adr;
            r_tab_data[cfg_idx] <= cfg_data;
        end
    end

    // Checker FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_num     <= '0;
            r_ign     <= 1'b0;
            r_tcnt    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            match_cnt <= '0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num     <= w_num_clamp;
                        r_ign     <= ign_en;
                        r_ptr     <= '0;
                        r_tcnt    <= '0;
                        match_cnt <= '0;
                        fail_adr  <= '0;
                        fail_data <= '0;
                        // An empty expectation list passes immediately.
                        if (w_num_clamp == '0) begin
                            r_state <= S_PASS;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_store && !w_hit) begin
                        // match_cnt stays at the failing entry index.
                        r_state   <= S_FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_adr  <= dataadr;
                        fail_data <= writedata;
                    end else if (w_store && w_last) begin
                        r_state   <= S_PASS;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b1;
                        match_cnt <= match_cnt + 1'b1;
                    end else begin
                        if (w_store) begin
                            r_ptr     <= r_ptr + 1'b1;
                            match_cnt <= match_cnt + 1'b1;
                        end
                        // Terminal store events above take priority over timeout.
                        if (w_tout) begin
                            r_state <= S_FAIL;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            fail    <= 1'b1;
                            timeout <= 1'b1;
                        end
                    end
                end
                S_PASS, S_FAIL: begin
                    // Sticky until cleared; captures and match_cnt are kept.
                    if (clear) begin
                        r_state <= S_IDLE;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        fail    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_seq_checker.sv
// Directed bench for store_seq_checker: a table of single-entry store checks
// followed by hand-written multi-cycle sequences (ordering, timeout, num=0,
// sticky behaviour, async reset mid-run).
module tb_store_seq_checker;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int IDXW  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             memwrite;
    logic [WIDTH-1:0] dataadr, writedata;
    logic             cfg_we;
    logic [IDXW-1:0]  cfg_idx;
    logic [WIDTH-1:0] cfg_adr, cfg_data;
    logic [IDXW:0]    cfg_num;
    logic             ign_en, start, clear;
    logic             busy, done, pass, fail, timeout;
    logic [IDXW:0]    match_cnt;
    logic [WIDTH-1:0] fail_adr, fail_data;

    int total = 0;
    int bad   = 0;

    store_seq_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW),
        .IGNORE_ADR(80), .TIMEOUT(20), .TCW(16)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_adr(cfg_adr), .cfg_data(cfg_data), .cfg_num(cfg_num),
        .ign_en(ign_en), .start(start), .clear(clear), .busy(busy),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .match_cnt(match_cnt), .fail_adr(fail_adr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ign;
        logic        pre_en;     // drive a store to address 80 first
        logic [31:0] e_adr, e_data;
        logic [31:0] s_adr, s_data;
        logic        x_pass, x_fail;
        logic [31:0] x_match, x_fadr, x_fdata;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = IDXW'(idx); cfg_adr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input int num, input logic ign);
        cfg_num = (IDXW+1)'(num); ign_en = ign; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0; dataadr = '0; writedata = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; memwrite = 0; dataadr = 0; writedata = 0;
        cfg_we = 0; cfg_idx = 0; cfg_adr = 0; cfg_data = 0; cfg_num = 0;
        ign_en = 0; start = 0; clear = 0;

        vecs[0] = '{1'b1, 1'b1, 32'd12, 32'hffff0000, 32'd12, 32'hffff0000, 1'b1, 1'b0, 32'd1, 32'd0, 32'd0};
        vecs[1] = '{1'b1, 1'b0, 32'd12, 32'hffff0000, 32'd12, 32'h0000ffff, 1'b0, 1'b1, 32'd0, 32'd12, 32'h0000ffff};
        vecs[2] = '{1'b0, 1'b0, 32'd12, 32'hffff0000, 32'd80, 32'h5,        1'b0, 1'b1, 32'd0, 32'd80, 32'h5};
        vecs[3] = '{1'b1, 1'b0, 32'd12, 32'hffff0000, 32'd16, 32'hffff0000, 1'b0, 1'b1, 32'd0, 32'd16, 32'hffff0000};

        tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_match", match_cnt, 0);
        reset = 1'b0;
        tick();

        // Single-entry table vectors
        for (int i = 0; i < 4; i++) begin
            load(0, vecs[i].e_adr, vecs[i].e_data);
            go(1, vecs[i].ign);
            chk($sformatf("v%0d_busy", i), busy, 1);
            if (vecs[i].pre_en) begin
                st(32'd80, 32'h5);
                chk($sformatf("v%0d_ign_busy", i), busy, 1);
                chk($sformatf("v%0d_ign_match", i), match_cnt, 0);
            end
            st(vecs[i].s_adr, vecs[i].s_data);
            chk($sformatf("v%0d_pass", i), pass, vecs[i].x_pass);
            chk($sformatf("v%0d_fail", i), fail, vecs[i].x_fail);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_tout", i), timeout, 0);
            chk($sformatf("v%0d_match", i), match_cnt, vecs[i].x_match);
            chk($sformatf("v%0d_fadr", i), fail_adr, vecs[i].x_fadr);
            chk($sformatf("v%0d_fdata", i), fail_data, vecs[i].x_fdata);
            do_clear();
            chk($sformatf("v%0d_clr_done", i), done, 0);
        end

        // Sequence of three with idle gaps
        load(0, 32'd0, 32'h1); load(1, 32'd4, 32'h2); load(2, 32'd8, 32'h3);
        go(3, 1'b0);
        st(32'd0, 32'h1); tick();
        chk("seq_m1", match_cnt, 1);
        chk("seq_busy1", busy, 1);
        st(32'd4, 32'h2); tick();
        chk("seq_m2", match_cnt, 2);
        st(32'd8, 32'h3);
        chk("seq_pass", pass, 1);
        chk("seq_m3", match_cnt, 3);
        // Stores after PASS are not observed
        st(32'd99, 32'h99);
        chk("seq_sticky_pass", pass, 1);
        chk("seq_sticky_fadr", fail_adr, 0);
        do_clear();

        // Swapped 2nd/3rd stores
        go(3, 1'b0);
        st(32'd0, 32'h1);
        st(32'd8, 32'h3);
        chk("swap_fail", fail, 1);
        chk("swap_match", match_cnt, 1);
        chk("swap_fadr", fail_adr, 8);
        chk("swap_fdata", fail_data, 3);
        do_clear();
        chk("swap_clr_match_held", match_cnt, 1);

        // Timeout: fail exactly 20 edges after the start edge
        go(1, 1'b0);
        chk("to_capture_cleared", fail_adr, 0);
        repeat (19) tick();
        chk("to_not_yet", fail, 0);
        chk("to_busy", busy, 1);
        tick();
        chk("to_fail", fail, 1);
        chk("to_flag", timeout, 1);
        chk("to_fadr", fail_adr, 0);
        // start without clear and stores are ignored while sticky
        start = 1'b1; tick(); start = 1'b0;
        st(32'd0, 32'h1);
        chk("to_sticky_fail", fail, 1);
        chk("to_sticky_busy", busy, 0);
        do_clear();
        chk("to_clr_fail", fail, 0);
        chk("to_clr_tout", timeout, 0);

        // num=0 passes right away
        go(0, 1'b0);
        chk("n0_pass", pass, 1);
        chk("n0_busy", busy, 0);
        do_clear();
        chk("n0_clr_pass", pass, 0);
        chk("n0_clr_done", done, 0);

        // Async reset mid-run, then rerun with retained table
        go(3, 1'b0);
        st(32'd0, 32'h1);
        chk("rst_pre_match", match_cnt, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_match", match_cnt, 0);
        tick();
        reset = 1'b0;
        tick();
        go(3, 1'b0);
        st(32'd0, 32'h1); st(32'd4, 32'h2); st(32'd8, 32'h3);
        chk("rst_rerun_pass", pass, 1);
        chk("rst_rerun_match", match_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
